// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_arb_pkg: shared state encoding, default sizes and destination-field helper for fifo_rr_arbiter.
package fifo_arb_pkg;
    localparam int N_QUEUES_DEF = 4;
    localparam int DATA_SIZE_DEF = 12;
    localparam int DEST_W = $clog2(N_QUEUES_DEF);
    localparam int PTR_W = DEST_W;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        ACTIVE = 3'd2,
        PAUSE  = 3'd3,
        ERROR  = 3'd4
    } arb_state_t;

    function automatic int unsigned dest_of(input logic [31:0] word, input int unsigned dsize, input int unsigned dw);
        return (word >> (dsize - dw)) & ((32'd1 << dw) - 32'd1);
    endfunction
endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: FIFO-side signals of the arbiter; slave is the arbiter, master the FIFO side.
interface fifo_rr_arbiter_if #(
    parameter int DATA_SIZE = 12,
    parameter int N_QUEUES = 4
);
    logic [DATA_SIZE-1:0]          th_af_cfg;
    logic [DATA_SIZE-1:0]          th_ae_cfg;
    logic [N_QUEUES-1:0]           in_empty;
    logic [N_QUEUES*DATA_SIZE-1:0] in_data;
    logic [N_QUEUES-1:0]           out_pause;
    logic                          fifo_error;
    logic [N_QUEUES-1:0]           in_pop;
    logic [N_QUEUES-1:0]           out_push;
    logic [DATA_SIZE-1:0]          out_data;
    logic [DATA_SIZE-1:0]          th_almost_full;
    logic [DATA_SIZE-1:0]          th_almost_empty;
    logic [2:0]                    arb_state;

    modport master (
        output th_af_cfg, th_ae_cfg, in_empty, in_data, out_pause, fifo_error,
        input  in_pop, out_push, out_data, th_almost_full, th_almost_empty, arb_state
    );
    modport slave (
        input  th_af_cfg, th_ae_cfg, in_empty, in_data, out_pause, fifo_error,
        output in_pop, out_push, out_data, th_almost_full, th_almost_empty, arb_state
    );
endinterface

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker, first requester at or after ptr_i (N must be a power of 2).
module rr_grant
    import fifo_arb_pkg::*;
#(
    parameter int N = N_QUEUES_DEF,
    parameter int PW = PTR_W
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);
    always_comb begin
        valid_o = 1'b0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[ptr_i + PW'(k)]) begin
                valid_o = 1'b1;
                idx_o = ptr_i + PW'(k);
            end
        end
        gnt_o = valid_o ? N'(1) << idx_o : '0;
    end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop/push scheduler between N input and N output FIFOs.
// Optional FIFO_ARB_STATS_EN adds per-input saturating 8-bit pop counters on grant_cnt.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int N_QUEUES = N_QUEUES_DEF,
    parameter logic [DATA_SIZE-1:0] TH_AF_DEF = 'h7,
    parameter logic [DATA_SIZE-1:0] TH_AE_DEF = 'h1
) (
    input logic clk,
    input logic reset,
    fifo_rr_arbiter_if.slave bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_QUEUES*8-1:0] grant_cnt
`endif
);
    localparam int DW = $clog2(N_QUEUES);

    arb_state_t state_q, state_d;
    logic [DW-1:0] rr_ptr_q, rr_ptr_d, p_idx_q, g_idx;
    logic p_valid_q, w_valid_q, g_valid, err, pop, push;
    logic [N_QUEUES-1:0] gnt;
    logic [DATA_SIZE-1:0] data_q, hold_q, th_af_q, th_ae_q;

    rr_grant #(.N(N_QUEUES), .PW(DW)) u_grant (
        .req_i(~bus.in_empty),
        .ptr_i(rr_ptr_q),
        .gnt_o(gnt),
        .idx_o(g_idx),
        .valid_o(g_valid)
    );

    always_comb begin
        err = bus.fifo_error || state_q == ERROR;
        pop = state_q == ACTIVE && !err && g_valid;
        push = w_valid_q && !err;
        rr_ptr_d = pop ? g_idx + DW'(1) : rr_ptr_q;
        state_d = bus.fifo_error ? ERROR :
                  state_q == INIT ? IDLE :
                  state_q == ERROR ? ERROR :
                  |bus.out_pause ? PAUSE :
                  &bus.in_empty ? IDLE : ACTIVE;
    end

    // out_data is muxed so a suppressed push never exposes a new word
    assign bus.in_pop = pop ? gnt : '0;
    assign bus.out_push = push ? N_QUEUES'(1) << dest_of(32'(data_q), DATA_SIZE, DW) : '0;
    assign bus.out_data = push ? data_q : hold_q;
    assign bus.th_almost_full = th_af_q;
    assign bus.th_almost_empty = th_ae_q;
    assign bus.arb_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            rr_ptr_q <= '0;
            p_valid_q <= 1'b0;
            p_idx_q <= '0;
            w_valid_q <= 1'b0;
            data_q <= '0;
            hold_q <= '0;
            th_af_q <= TH_AF_DEF;
            th_ae_q <= TH_AE_DEF;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            p_valid_q <= pop;
            p_idx_q <= g_idx;
            w_valid_q <= p_valid_q && !err;
            hold_q <= bus.out_data;
            if (p_valid_q) data_q <= bus.in_data[p_idx_q*DATA_SIZE +: DATA_SIZE];
            if (state_q == INIT) begin
                th_af_q <= bus.th_af_cfg;
                th_ae_q <= bus.th_ae_cfg;
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [7:0] cnt_q [N_QUEUES];
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_QUEUES; i++) begin
            if (reset) cnt_q[i] <= '0;
            else if (bus.in_pop[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
        end
    end
    for (genvar g = 0; g < N_QUEUES; g++) begin : g_cnt
        assign grant_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: queue-backed FIFO environment plus scheduled-push reference model for fifo_rr_arbiter.
module tb_fifo_rr_arbiter;
    import fifo_arb_pkg::*;
    localparam int DS = 12;
    localparam int NQ = 4;

    typedef struct {
        int due;
        logic [DS-1:0] data;
    } sched_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_rr_arbiter_if #(.DATA_SIZE(DS), .N_QUEUES(NQ)) bus ();
`ifdef FIFO_ARB_STATS_EN
    logic [NQ*8-1:0] grant_cnt;
`endif

    fifo_rr_arbiter #(.DATA_SIZE(DS), .N_QUEUES(NQ), .TH_AF_DEF(12'h7), .TH_AE_DEF(12'h1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [DS-1:0] fq [NQ][$];
    logic [DS-1:0] rd [NQ];
    logic [NQ-1:0] pop_seen = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NQ; i++) begin
            bus.in_empty[i] = fq[i].size() == 0;
            bus.in_data[i*DS +: DS] = rd[i];
        end
    endtask

    // FIFOs present the popped word one cycle after the pop strobe
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++)
            if (pop_seen[i] && fq[i].size() != 0) rd[i] = fq[i].pop_front();
        refresh();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < NQ; i++)
            for (int k = 0; k < n; k++) fq[i].push_back(DS'($urandom_range(0, 4095)));
        refresh();
    endtask

    sched_t sch[$];
    int cyc = 0;
    bit m_known = 0;
    int m_state, m_ptr, g;
    logic [DS-1:0] m_af, m_ae, m_last, xp_data;
    logic [NQ-1:0] e, xp_pop, xp_push;
    bit ferr;

    always @(negedge clk) begin
        e = bus.in_empty;
        ferr = bus.fifo_error;
        pop_seen = bus.in_pop;
        if (m_known) begin
            g = -1;
            if (m_state == 2 && !ferr)
                for (int k = 0; k < NQ; k++)
                    if (g < 0 && !e[(m_ptr + k) % NQ]) g = (m_ptr + k) % NQ;
            xp_pop = g >= 0 ? NQ'(1) << g : '0;
            xp_push = '0;
            xp_data = m_last;
            if (sch.size() != 0 && sch[0].due == cyc) begin
                if (!ferr && m_state != 4) begin
                    xp_push = NQ'(1) << sch[0].data[DS-1 -: 2];
                    xp_data = sch[0].data;
                end
                void'(sch.pop_front());
            end
            check("in_pop", 32'(bus.in_pop), 32'(xp_pop));
            check("out_push", 32'(bus.out_push), 32'(xp_push));
            check("out_data", 32'(bus.out_data), 32'(xp_data));
            check("arb_state", 32'(bus.arb_state), 32'(m_state));
            check("th_almost_full", 32'(bus.th_almost_full), 32'(m_af));
            check("th_almost_empty", 32'(bus.th_almost_empty), 32'(m_ae));
            check("pop_of_empty", 32'(bus.in_pop & e), 32'd0);
            m_last = xp_data;
            if (g >= 0) begin
                sch.push_back('{cyc + 2, fq[g][0]});
                m_ptr = (g + 1) % NQ;
            end
            if (m_state == 0) begin
                m_af = bus.th_af_cfg;
                m_ae = bus.th_ae_cfg;
            end
            m_state = ferr ? 4 : m_state == 0 ? 1 : m_state == 4 ? 4 : |bus.out_pause ? 3 : &e ? 1 : 2;
            if (ferr) sch.delete();
        end
        if (reset) begin
            m_known = 1;
            m_state = 0;
            m_ptr = 0;
            m_af = 12'h7;
            m_ae = 12'h1;
            m_last = '0;
            sch.delete();
        end
        cyc++;
    end

    initial begin
        int npush, ec;
        bus.th_af_cfg = 12'h6;
        bus.th_ae_cfg = 12'h2;
        bus.out_pause = '0;
        bus.fifo_error = 1'b0;
        for (int i = 0; i < NQ; i++) rd[i] = '0;
        refresh();
        // threshold capture after a two-cycle reset
        tick();
        tick();
        reset = 1'b0;
        tick();
        #1;
        check("init_th_af", 32'(bus.th_almost_full), 32'h6);
        check("init_th_ae", 32'(bus.th_almost_empty), 32'h2);
        check("init_idle", 32'(bus.arb_state), 32'(IDLE));
        // two queues, pop-to-push latency of two
        fq[0].push_back(12'h01A);
        fq[2].push_back(12'hC2A);
        refresh();
        tick();
        #1 check("pop_q0", 32'(bus.in_pop), 32'h1);
        tick();
        #1 check("pop_q2", 32'(bus.in_pop), 32'h4);
        tick();
        #1 check("push_out0", 32'(bus.out_push), 32'h1);
        check("data_01a", 32'(bus.out_data), 32'h01A);
        tick();
        #1 check("push_out3", 32'(bus.out_push), 32'h8);
        check("data_c2a", 32'(bus.out_data), 32'hC2A);
        // all queues busy from a fresh pointer
        fill(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_order", 32'(bus.in_pop), 32'd1 << (k % 4));
            tick();
        end
        repeat (25) tick();
        // pause while streaming
        fill(8);
        repeat (3) tick();
        bus.out_pause = 4'b0010;
        npush = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            if (k == 0) begin
                check("pause_state", 32'(bus.arb_state), 32'(PAUSE));
                check("pause_no_pop", 32'(bus.in_pop), 32'd0);
            end
            if (|bus.out_push) npush++;
        end
        check("pause_inflight", 32'(npush), 32'd2);
        bus.out_pause = '0;
        tick();
        #1 check("resume", 32'(bus.arb_state), 32'(ACTIVE));
        // error pulse mid-stream
        tick();
        tick();
        bus.fifo_error = 1'b1;
        #1 check("err_pop_now", 32'(bus.in_pop), 32'd0);
        check("err_push_now", 32'(bus.out_push), 32'd0);
        tick();
        bus.fifo_error = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 check("err_pop", 32'(bus.in_pop), 32'd0);
            check("err_push", 32'(bus.out_push), 32'd0);
            check("err_state", 32'(bus.arb_state), 32'(ERROR));
            tick();
        end
        // all empty for eight cycles
        for (int i = 0; i < NQ; i++) fq[i].delete();
        refresh();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            #1 check("empty_no_pop", 32'(bus.in_pop), 32'd0);
            check("empty_idle", 32'(bus.arb_state), 32'(IDLE));
        end
        // randomized traffic with pauses, errors and resets
        ec = 0;
        for (int n = 0; n < 500; n++) begin
            tick();
            for (int i = 0; i < NQ; i++)
                if (fq[i].size() < 6 && $urandom_range(0, 2) == 0) fq[i].push_back(DS'($urandom_range(0, 4095)));
            bus.out_pause = ($urandom_range(0, 9) == 0) ? NQ'($urandom_range(1, 15)) : '0;
            bus.fifo_error = 1'b0;
            reset = 1'b0;
            if (ec > 0) ec++;
            if (ec == 0 && $urandom_range(0, 149) == 0) begin
                bus.fifo_error = 1'b1;
                ec = 1;
            end
            if (ec == 5 || $urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                ec = 0;
                bus.th_af_cfg = DS'($urandom_range(0, 4095));
                bus.th_ae_cfg = DS'($urandom_range(0, 4095));
            end
            refresh();
        end
        bus.fifo_error = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
